// File: rtl/fwd_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_pkg
// Shared pipeline constants for the hazard/forwarding scoreboard:
//   - stage indices after decode (E/M/W)
//   - typical tnew/tuse encodings per instruction class
//   - result-source class codes reported on fwd_src
// No ports; imported by the scoreboard, its match sub-module and the interface.
// -----------------------------------------------------------------------------
package fwd_scoreboard_pkg;

    // Stage index k of the tracked writer shift register
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    // tnew: cycles from entering E until the result exists
    localparam int TNEW_PC8  = 0;   // jal/jalr link value known at issue
    localparam int TNEW_ALU  = 1;   // available at end of E
    localparam int TNEW_LOAD = 2;   // available at end of M

    // tuse: cycles from D until the operand is consumed
    localparam int TUSE_BRANCH = 0; // compared in D
    localparam int TUSE_ALU    = 1; // consumed in E
    localparam int TUSE_STORE  = 2; // store data consumed in M

    // Result-source classes
    localparam int SRC_ALU = 0;
    localparam int SRC_PC8 = 1;
    localparam int SRC_IMM = 2;
    localparam int SRC_MD  = 3;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_if
// Decode-side bundle between the D stage (master) and the scoreboard (slave).
//   master -> slave : flush, issue_{valid,addr,tnew,src}, src_{valid,addr,tuse}
//   slave -> master : stall, fwd_sel, fwd_src
// Per-port fields are flat vectors, port p at [p*W +: W].
// -----------------------------------------------------------------------------
interface fwd_scoreboard_if #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int STAGES  = 3,
    parameter int NUM_SRC = 2,
    parameter int SRCW    = 2
);
    localparam int SW = $clog2(STAGES + 1);

    logic                      flush;
    logic                      issue_valid;
    logic [AW-1:0]             issue_addr;
    logic [TW-1:0]             issue_tnew;
    logic [SRCW-1:0]           issue_src;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*AW-1:0]     src_addr;
    logic [NUM_SRC*TW-1:0]     src_tuse;
    logic                      stall;
    logic [NUM_SRC*SW-1:0]     fwd_sel;
    logic [NUM_SRC*SRCW-1:0]   fwd_src;

    modport master (
        output flush, issue_valid, issue_addr, issue_tnew, issue_src,
        output src_valid, src_addr, src_tuse,
        input  stall, fwd_sel, fwd_src
    );

    modport slave (
        input  flush, issue_valid, issue_addr, issue_tnew, issue_src,
        input  src_valid, src_addr, src_tuse,
        output stall, fwd_sel, fwd_src
    );

endinterface

// File: rtl/fwd_scoreboard_match.sv
// -----------------------------------------------------------------------------
// fwd_sb_match
// One decode read port: finds the youngest in-flight writer of i_addr and
// decides forward / stall / read-register-file.
//   i_valid, i_addr, i_tuse     : read port request
//   i_ent_*                     : scoreboard entries, index 1 = youngest (E)
//   o_stall                     : this port needs the decode stage held
//   o_sel                       : 0 = register file, k = forward from stage k
//   o_src                       : source class of the forwarding entry, else 0
// -----------------------------------------------------------------------------
module fwd_sb_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int STAGES = 3,
    parameter int SRCW   = 2,
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic                        i_valid,
    input  logic [AW-1:0]               i_addr,
    input  logic [TW-1:0]               i_tuse,
    input  logic [STAGES:1]             i_ent_v,
    input  logic [STAGES:1][AW-1:0]     i_ent_addr,
    input  logic [STAGES:1][TW-1:0]     i_ent_tnew,
    input  logic [STAGES:1][SRCW-1:0]   i_ent_src,
    output logic                        o_stall,
    output logic [SW-1:0]               o_sel,
    output logic [SRCW-1:0]             o_src
);

    logic            w_hit;
    logic [SW-1:0]   w_k;
    logic [TW-1:0]   w_tnew;
    logic [SRCW-1:0] w_src;
    logic            w_en;

    assign w_en = i_valid && (i_addr != '0);

    // Scan oldest to youngest so the last hit (lowest k) wins: a younger
    // writer of the same register shadows older ones.
    always_comb begin
        w_hit  = 1'b0;
        w_k    = '0;
        w_tnew = '0;
        w_src  = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (i_ent_v[k] && (i_ent_addr[k] == i_addr)) begin
                w_hit  = 1'b1;
                w_k    = SW'(k);
                w_tnew = i_ent_tnew[k];
                w_src  = i_ent_src[k];
            end
        end
    end

    // Result ready -> forward now. Not ready but needed later than it
    // arrives -> no stall; a later stage's forward path picks it up.
    always_comb begin
        o_stall = 1'b0;
        o_sel   = '0;
        o_src   = '0;
        if (w_en && w_hit) begin
            if (w_tnew == '0) begin
                o_sel = w_k;
                o_src = w_src;
            end else if (w_tnew > i_tuse) begin
                o_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Hazard/forwarding scoreboard beside the decode stage of the in-order MIPS
// pipeline. Tracks in-flight register writers from E onward and resolves
// stall vs. forward for every decode read port.
//   clk   : rising-edge clock
//   reset : synchronous, active low
//   bus   : fwd_scoreboard_if.slave (issue, read ports, stall/forward out)
// -----------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int STAGES  = 3,
    parameter int NUM_SRC = 2,
    parameter int SRCW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    fwd_scoreboard_if.slave  bus
);

    localparam int SW = $clog2(STAGES + 1);

    logic [STAGES:1]                r_v;
    logic [STAGES:1][AW-1:0]        r_addr;
    logic [STAGES:1][TW-1:0]        r_tnew;
    logic [STAGES:1][SRCW-1:0]      r_src;

    logic [NUM_SRC-1:0]             w_stall_req;
    logic [NUM_SRC-1:0][SW-1:0]     w_sel;
    logic [NUM_SRC-1:0][SRCW-1:0]   w_src;
    logic                           w_stall;

    assign w_stall     = |w_stall_req;
    assign bus.stall   = w_stall;
    assign bus.fwd_sel = w_sel;
    assign bus.fwd_src = w_src;

    // Writer shift register. A stall holds D, so E receives a bubble; the
    // older entries keep advancing. Writes to $0 never enter as valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v    <= '0;
            r_addr <= '0;
            r_tnew <= '0;
            r_src  <= '0;
        end else if (bus.flush) begin
            r_v <= '0;
        end else begin
            if (w_stall) begin
                r_v[STG_E]    <= 1'b0;
                r_addr[STG_E] <= '0;
                r_tnew[STG_E] <= '0;
                r_src[STG_E]  <= '0;
            end else begin
                r_v[STG_E]    <= bus.issue_valid && (bus.issue_addr != '0);
                r_addr[STG_E] <= bus.issue_addr;
                r_tnew[STG_E] <= bus.issue_tnew;
                r_src[STG_E]  <= bus.issue_src;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_v[k+1]    <= r_v[k];
                r_addr[k+1] <= r_addr[k];
                r_tnew[k+1] <= (r_tnew[k] == '0) ? '0 : r_tnew[k] - TW'(1);
                r_src[k+1]  <= r_src[k];
            end
        end
    end

    for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
        fwd_sb_match #(
            .AW     (AW),
            .TW     (TW),
            .STAGES (STAGES),
            .SRCW   (SRCW),
            .SW     (SW)
        ) u_match (
            .i_valid    (bus.src_valid[p]),
            .i_addr     (bus.src_addr[p*AW +: AW]),
            .i_tuse     (bus.src_tuse[p*TW +: TW]),
            .i_ent_v    (r_v),
            .i_ent_addr (r_addr),
            .i_ent_tnew (r_tnew),
            .i_ent_src  (r_src),
            .o_stall    (w_stall_req[p]),
            .o_sel      (w_sel[p]),
            .o_src      (w_src[p])
        );
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
// Directed vectors with hand-computed expectations for fwd_scoreboard
// (AW=5, TW=2, STAGES=3, NUM_SRC=2, SRCW=2 -> SW=2).
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    fwd_scoreboard_if #(.AW(5), .TW(2), .STAGES(3), .NUM_SRC(2), .SRCW(2)) sb_if ();

    fwd_scoreboard #(.AW(5), .TW(2), .STAGES(3), .NUM_SRC(2), .SRCW(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int p, input logic v, input int a, input int t);
        sb_if.src_valid[p]       = v;
        sb_if.src_addr[p*5 +: 5] = 5'(a);
        sb_if.src_tuse[p*2 +: 2] = 2'(t);
    endtask

    task automatic issue(input int a, input int t, input int s);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_addr  = 5'(a);
        sb_if.issue_tnew  = 2'(t);
        sb_if.issue_src   = 2'(s);
        cyc();
        sb_if.issue_valid = 1'b0;
    endtask

    // Empty the pipeline and idle the read ports
    task automatic clr();
        set_src(0, 1'b0, 0, 0);
        set_src(1, 1'b0, 0, 0);
        sb_if.issue_valid = 1'b0;
        sb_if.flush = 1'b1;
        cyc();
        sb_if.flush = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        sb_if.flush       = 1'b0;
        sb_if.issue_valid = 1'b1;
        sb_if.issue_addr  = 5'd5;
        sb_if.issue_tnew  = 2'd0;
        sb_if.issue_src   = 2'd0;
        sb_if.src_valid   = '0;
        sb_if.src_addr    = '0;
        sb_if.src_tuse    = '0;

        // 1: reset held with an issue pending -> nothing tracked
        cyc();
        cyc();
        reset = 1'b1;
        sb_if.issue_valid = 1'b0;
        set_src(0, 1'b1, 5, 0);
        #1;
        chk("rst_stall", int'(sb_if.stall), 0);
        chk("rst_sel0",  int'(sb_if.fwd_sel[1:0]), 0);
        chk("rst_src0",  int'(sb_if.fwd_src[1:0]), 0);

        // 2: lw $2 tnew=2, consumer tuse=1 -> one stall cycle, then late forward
        clr();
        issue(2, TNEW_LOAD, SRC_ALU);
        set_src(0, 1'b1, 2, TUSE_ALU);
        #1;
        chk("lw_stall",   int'(sb_if.stall), 1);
        cyc();
        chk("lw_release", int'(sb_if.stall), 0);
        chk("lw_sel0",    int'(sb_if.fwd_sel[1:0]), 0);
        cyc();
        chk("lw_sel_w",   int'(sb_if.fwd_sel[1:0]), 3);

        // 3: jal $31 (PC+8, tnew=0) -> forward from E on both ports
        clr();
        issue(31, TNEW_PC8, SRC_PC8);
        set_src(0, 1'b1, 31, TUSE_BRANCH);
        set_src(1, 1'b1, 31, TUSE_ALU);
        #1;
        chk("jal_stall", int'(sb_if.stall), 0);
        chk("jal_sel0",  int'(sb_if.fwd_sel[1:0]), 1);
        chk("jal_src0",  int'(sb_if.fwd_src[1:0]), SRC_PC8);
        chk("jal_sel1",  int'(sb_if.fwd_sel[3:2]), 1);
        chk("jal_src1",  int'(sb_if.fwd_src[3:2]), SRC_PC8);

        // 4: $5 in E (tnew=1) shadows $5 in M (tnew=0)
        clr();
        issue(5, TNEW_ALU, SRC_MD);
        issue(5, TNEW_ALU, SRC_IMM);
        set_src(0, 1'b1, 5, 0);
        set_src(1, 1'b1, 5, 1);
        #1;
        chk("shadow_stall", int'(sb_if.stall), 1);
        chk("shadow_sel0",  int'(sb_if.fwd_sel[1:0]), 0);
        chk("shadow_sel1",  int'(sb_if.fwd_sel[3:2]), 0);
        set_src(0, 1'b0, 5, 0);
        #1;
        chk("novalid_stall", int'(sb_if.stall), 0);

        // 5: writes and reads of $0 are ignored
        clr();
        issue(0, TNEW_ALU, SRC_ALU);
        set_src(0, 1'b1, 0, 0);
        set_src(1, 1'b1, 0, 0);
        #1;
        chk("zero_stall", int'(sb_if.stall), 0);
        chk("zero_sel0",  int'(sb_if.fwd_sel[1:0]), 0);
        chk("zero_sel1",  int'(sb_if.fwd_sel[3:2]), 0);

        // 6a: flush during a stall
        clr();
        issue(7, TNEW_LOAD, SRC_ALU);
        set_src(0, 1'b1, 7, 0);
        #1;
        chk("fl_pre_stall", int'(sb_if.stall), 1);
        sb_if.flush = 1'b1;
        cyc();
        sb_if.flush = 1'b0;
        #1;
        chk("fl_stall", int'(sb_if.stall), 0);
        chk("fl_sel0",  int'(sb_if.fwd_sel[1:0]), 0);

        // 6b: reset during a stall
        issue(7, TNEW_LOAD, SRC_ALU);
        #1;
        chk("rs_pre_stall", int'(sb_if.stall), 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        chk("rs_stall", int'(sb_if.stall), 0);
        chk("rs_sel0",  int'(sb_if.fwd_sel[1:0]), 0);
        cyc();
        chk("rs_hold_stall", int'(sb_if.stall), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
